frame_update_sched: RTL and testbench
=====================================

# frame_update_sched

Frame-synchronous scheduler between the VGA timing logic and the processor/regfile datapath. It turns each rising edge of `screenEnd` into a single-cycle frame tick for software, waits for software to report that the ball update for that frame is complete, then commits the processor's ball coordinates, clamped to the screen, into display shadow registers. The display side therefore never sees a half-updated position. It also detects and counts frames that software failed to finish in time.

## Interface
- `X_MAX`, 639, largest legal display x coordinate
- `Y_MAX`, 479, largest legal display y coordinate
- `X_INIT`, 320, display x value at reset
- `Y_INIT`, 240, display y value at reset

- `clock`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `screenEnd`  in  1  level from VGA timing, synchronous to `clock`; high during vertical blank
- `cpu_done`  in  1  one-cycle pulse from the regfile when software writes the frame-done register
- `cpu_ball_x`  in  32  processor ball x, signed two's complement
- `cpu_ball_y`  in  32  processor ball y, signed two's complement
- `frame_tick`  out  1  registered one-cycle pulse that starts a software frame
- `disp_ball_x`  out  10  committed, clamped x for the renderer
- `disp_ball_y`  out  9  committed, clamped y for the renderer
- `busy`  out  1  high while software owns the frame (state COMPUTE)
- `overrun`  out  1  sticky; set on any missed frame
- `frame_count`  out  16  frames committed, wraps modulo 2^16
- `missed_count`  out  16  frames missed, saturates at 16'hFFFF

## Operation
- Edge detect:
  - `se_q` registers `screenEnd` every cycle.
  - `edge = screenEnd & ~se_q`.
- States: WAIT_FRAME, COMPUTE, COMMIT.
- WAIT_FRAME:
  - On `edge`: go to COMPUTE and pulse `frame_tick`.
  - `cpu_done` is ignored.
- COMPUTE (`busy`=1):
  - `cpu_done` alone: go to COMMIT.
  - `edge` without `cpu_done` (overrun):
    - stay in COMPUTE and re-pulse `frame_tick`;
    - `missed_count`++ and set `overrun`;
    - `disp_*` are unchanged.
  - `cpu_done` and `edge` in the same cycle:
    - done wins and the state goes to COMMIT;
    - set the `pending` flag; no miss is counted.
- COMMIT (exactly one cycle):
  - Load `disp_ball_x` and `disp_ball_y` from the clamped inputs sampled in this cycle.
  - `frame_count`++.
  - If `pending` is set: clear it, go to COMPUTE and pulse `frame_tick`.
  - Otherwise: go to WAIT_FRAME.
  - An `edge` arriving during COMMIT behaves as `pending`.
- Clamping (inputs signed 32-bit):
  - value < 0 gives 0;
  - value > MAX gives MAX;
  - otherwise the low 10 bits (x) or 9 bits (y).
- `overrun` clears only on `reset`.

## Timing
- Reset values:
  - state WAIT_FRAME; `se_q`=0; `pending`=0;
  - `frame_tick`=0, `busy`=0, `overrun`=0;
  - `disp_ball_x`=`X_INIT`, `disp_ball_y`=`Y_INIT`;
  - both counters 0.
- `screenEnd` high at rising edge k with `se_q`=0: `frame_tick`=1 and `busy`=1 during cycle k+1.
- `cpu_done` sampled at edge j in COMPUTE:
  - cycle j+1 is COMMIT;
  - new `disp_*` and `frame_count` are visible in cycle j+2;
  - `busy` falls in cycle j+1.
- Minimum edge-to-display latency is 3 cycles, which requires `cpu_done` in the first COMPUTE cycle.
- `screenEnd` held high does not retrigger; a new frame needs a low-then-high transition.
- Reset asserted mid-frame aborts the frame immediately, with no commit and no tick in the following cycle.

## Configuration
- `FRAME_STATS_EN` defined:
  - `frame_count`, `missed_count` and `overrun` are implemented as described above.
- `FRAME_STATS_EN` undefined:
  - these three outputs are tied to 0 and their counters are not synthesized;
  - scheduling, tick and commit behaviour are unchanged.

## Test plan
- Reset, then `screenEnd` 0→1 at cycle 5 with `cpu_done` at cycle 10, x=100, y=50 -> `frame_tick` in cycle 6 only; `disp`=(100,50) from cycle 12; `frame_count`=1.
- Clamp: x=-5, y=600 -> `disp`=(0,479). x=32'h7FFFFFFF -> `disp_ball_x`=639.
- Overrun: edge with no `cpu_done`, then a second edge -> second `frame_tick`; `missed_count`=1; `overrun`=1; `disp` stays (320,240).
- Simultaneous `cpu_done` and `edge` in COMPUTE -> COMMIT, then COMPUTE with `frame_tick`; `frame_count`=1; `missed_count`=0.
- `cpu_done` in WAIT_FRAME, and `screenEnd` held high for 100 cycles -> no commit, exactly one `frame_tick`. Reset during COMPUTE -> all reset values next cycle.
- Build without `FRAME_STATS_EN` and repeat the overrun test -> counters and `overrun` read 0, `frame_tick` identical.

Source files
------------

// File: rtl/frame_update_sched.sv
// Frame scheduler: screenEnd rising edge -> frame_tick, waits for cpu_done, then commits clamped ball position.
// Edge-to-display latency is 3 cycles minimum; no backpressure. Frame statistics exist only with FRAME_STATS_EN defined.
module frame_update_sched #(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic        cpu_done,
  input  logic [31:0] cpu_ball_x,
  input  logic [31:0] cpu_ball_y,
  output logic        frame_tick,
  output logic [9:0]  disp_ball_x,
  output logic [8:0]  disp_ball_y,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] frame_count,
  output logic [15:0] missed_count
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    COMPUTE    = 2'd1,
    COMMIT     = 2'd2
  } state_t;

  localparam logic [9:0] X_MAX_V  = 10'(X_MAX);
  localparam logic [8:0] Y_MAX_V  = 9'(Y_MAX);
  localparam logic [9:0] X_INIT_V = 10'(X_INIT);
  localparam logic [8:0] Y_INIT_V = 9'(Y_INIT);

  state_t      state_q, state_d;
  logic        se_q;
  logic        pending_q, pending_d;
  logic        frame_tick_q, frame_tick_d;
  logic [9:0]  disp_x_q, disp_x_d;
  logic [8:0]  disp_y_q, disp_y_d;
  logic        se_edge;

  function automatic logic [9:0] clamp_x(input logic [31:0] v);
    if (v[31])
      clamp_x = '0;
    else if ($signed(v) > X_MAX)
      clamp_x = X_MAX_V;
    else
      clamp_x = v[9:0];
  endfunction

  function automatic logic [8:0] clamp_y(input logic [31:0] v);
    if (v[31])
      clamp_y = '0;
    else if ($signed(v) > Y_MAX)
      clamp_y = Y_MAX_V;
    else
      clamp_y = v[8:0];
  endfunction

  assign se_edge = screenEnd & ~se_q;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    frame_tick_d = 1'b0;
    disp_x_d     = disp_x_q;
    disp_y_d     = disp_y_q;
    case (state_q)
      WAIT_FRAME: begin
        if (se_edge) begin
          state_d      = COMPUTE;
          frame_tick_d = 1'b1;
        end
      end
      COMPUTE: begin
        // done beats a coincident edge; that edge is remembered as pending
        if (cpu_done) begin
          state_d = COMMIT;
          if (se_edge)
            pending_d = 1'b1;
        end else if (se_edge) begin
          frame_tick_d = 1'b1;
        end
      end
      COMMIT: begin
        disp_x_d  = clamp_x(cpu_ball_x);
        disp_y_d  = clamp_y(cpu_ball_y);
        pending_d = 1'b0;
        if (pending_q || se_edge) begin
          state_d      = COMPUTE;
          frame_tick_d = 1'b1;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      se_q         <= 1'b0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      disp_x_q     <= X_INIT_V;
      disp_y_q     <= Y_INIT_V;
    end else begin
      state_q      <= state_d;
      se_q         <= screenEnd;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      disp_x_q     <= disp_x_d;
      disp_y_q     <= disp_y_d;
    end
  end

  assign frame_tick  = frame_tick_q;
  assign disp_ball_x = disp_x_q;
  assign disp_ball_y = disp_y_q;
  assign busy        = (state_q == COMPUTE);

`ifdef FRAME_STATS_EN
  logic        commit_now, miss_now;
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] missed_count_q, missed_count_d;
  logic        overrun_q, overrun_d;

  always_comb begin
    commit_now     = (state_q == COMMIT);
    miss_now       = (state_q == COMPUTE) && se_edge && !cpu_done;
    frame_count_d  = frame_count_q;
    missed_count_d = missed_count_q;
    overrun_d      = overrun_q;
    if (commit_now)
      frame_count_d = frame_count_q + 16'd1;
    if (miss_now) begin
      overrun_d = 1'b1;
      if (missed_count_q != 16'hFFFF)
        missed_count_d = missed_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q  <= '0;
      missed_count_q <= '0;
      overrun_q      <= 1'b0;
    end else begin
      frame_count_q  <= frame_count_d;
      missed_count_q <= missed_count_d;
      overrun_q      <= overrun_d;
    end
  end

  assign frame_count  = frame_count_q;
  assign missed_count = missed_count_q;
  assign overrun      = overrun_q;
`else
  assign frame_count  = '0;
  assign missed_count = '0;
  assign overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_update_sched.sv
// Bench for frame_update_sched: directed scenarios with literal expectations, then randomized traffic against a frame-level model.
module tb_frame_update_sched;

`ifdef FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, screenEnd, cpu_done;
  logic [31:0] cpu_ball_x, cpu_ball_y;
  logic        frame_tick, busy, overrun;
  logic [9:0]  disp_ball_x;
  logic [8:0]  disp_ball_y;
  logic [15:0] frame_count, missed_count;

  frame_update_sched dut (
    .clock        (clock),
    .reset        (reset),
    .screenEnd    (screenEnd),
    .cpu_done     (cpu_done),
    .cpu_ball_x   (cpu_ball_x),
    .cpu_ball_y   (cpu_ball_y),
    .frame_tick   (frame_tick),
    .disp_ball_x  (disp_ball_x),
    .disp_ball_y  (disp_ball_y),
    .busy         (busy),
    .overrun      (overrun),
    .frame_count  (frame_count),
    .missed_count (missed_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks    = 0;
  bit chk_en   = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: who owns the frame, whether a frame start is queued behind a commit
  localparam int IDLE = 0, SW_OWNS = 1, COMMITTING = 2;
  int m_owner = IDLE;
  bit m_prev_se, m_queued, m_tick, m_ovr;
  int m_x, m_y, m_frames, m_missed;

  function automatic int clampv(input logic [31:0] raw, input int mx);
    int v;
    v = int'($signed(raw));
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  always @(posedge clock) begin
    bit new_frame;
    if (reset) begin
      m_owner = IDLE; m_prev_se = 0; m_queued = 0; m_tick = 0; m_ovr = 0;
      m_x = 320; m_y = 240; m_frames = 0; m_missed = 0;
    end else begin
      new_frame = screenEnd && !m_prev_se;
      m_prev_se = screenEnd;
      m_tick = 0;
      if (m_owner == IDLE) begin
        if (new_frame) begin m_owner = SW_OWNS; m_tick = 1; end
      end else if (m_owner == SW_OWNS) begin
        if (cpu_done) begin
          m_owner = COMMITTING;
          m_queued = new_frame;
        end else if (new_frame) begin
          m_tick = 1; m_ovr = 1;
          if (m_missed < 65535) m_missed++;
        end
      end else begin
        m_x = clampv(cpu_ball_x, 639);
        m_y = clampv(cpu_ball_y, 479);
        m_frames = (m_frames + 1) % 65536;
        if (m_queued || new_frame) begin m_owner = SW_OWNS; m_tick = 1; end
        else m_owner = IDLE;
        m_queued = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      if (frame_tick === 1'b1) ticks++;
      cmp("frame_tick", frame_tick, m_tick);
      cmp("busy", busy, m_owner == SW_OWNS);
      cmp("disp_ball_x", disp_ball_x, m_x);
      cmp("disp_ball_y", disp_ball_y, m_y);
      cmp("overrun", overrun, STATS ? m_ovr : 0);
      cmp("frame_count", frame_count, STATS ? m_frames : 0);
      cmp("missed_count", missed_count, STATS ? m_missed : 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; screenEnd = 1'b0; cpu_done = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_coord();
    logic [31:0] b [8];
    b = '{32'hFFFF_FFFF, 32'd0, 32'd639, 32'd640, 32'd479, 32'd480, 32'h7FFF_FFFF, 32'h8000_0000};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 760)) - 32'd60;
      2: return b[$urandom_range(0, 7)];
      default: return 32'($urandom_range(0, 400));
    endcase
  endfunction

  initial begin
    int t0;
    reset = 1'b1; screenEnd = 1'b0; cpu_done = 1'b0;
    cpu_ball_x = '0; cpu_ball_y = '0;
    step(1);
    chk_en = 1'b1;
    step(1);
    reset = 1'b0;

    cmp("rst_tick", frame_tick, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_x", disp_ball_x, 320);
    cmp("rst_y", disp_ball_y, 240);
    cmp("rst_fc", frame_count, 0);
    cmp("rst_ovr", overrun, 0);

    // basic frame: done arrives several cycles into COMPUTE
    step(3);
    screenEnd = 1'b1; cpu_ball_x = 32'd100; cpu_ball_y = 32'd50;
    t0 = ticks;
    step(1);
    cmp("t1_tick", frame_tick, 1);
    cmp("t1_busy", busy, 1);
    step(4);
    cpu_done = 1'b1;
    step(1);
    cpu_done = 1'b0;
    cmp("t1_commit_busy", busy, 0);
    step(1);
    cmp("t1_x", disp_ball_x, 100);
    cmp("t1_y", disp_ball_y, 50);
    cmp("t1_fc", frame_count, STATS ? 1 : 0);
    step(2);
    cmp("t1_ticks", ticks - t0, 1);

    // clamping
    screenEnd = 1'b0; step(1);
    screenEnd = 1'b1; cpu_ball_x = -32'sd5; cpu_ball_y = 32'd600; step(1);
    cpu_done = 1'b1; step(1); cpu_done = 1'b0; step(1);
    cmp("clamp_x_neg", disp_ball_x, 0);
    cmp("clamp_y_hi", disp_ball_y, 479);
    screenEnd = 1'b0; step(1);
    screenEnd = 1'b1; cpu_ball_x = 32'h7FFF_FFFF; cpu_ball_y = 32'hFFFF_FFFF; step(1);
    cpu_done = 1'b1; step(1); cpu_done = 1'b0; step(1);
    cmp("clamp_x_max", disp_ball_x, 639);
    cmp("clamp_y_neg", disp_ball_y, 0);

    // overrun
    do_reset();
    step(1);
    screenEnd = 1'b1; step(1);
    screenEnd = 1'b0; step(1);
    screenEnd = 1'b1; step(1);
    cmp("ovr_tick", frame_tick, 1);
    cmp("ovr_busy", busy, 1);
    cmp("ovr_missed", missed_count, STATS ? 1 : 0);
    cmp("ovr_flag", overrun, STATS ? 1 : 0);
    cmp("ovr_x", disp_ball_x, 320);
    cmp("ovr_y", disp_ball_y, 240);
    cpu_done = 1'b1; step(1); cpu_done = 1'b0; step(2);

    // done and edge together
    do_reset();
    step(1);
    screenEnd = 1'b1; step(1);
    screenEnd = 1'b0; step(1);
    screenEnd = 1'b1; cpu_done = 1'b1; cpu_ball_x = 32'd7; cpu_ball_y = 32'd9; step(1);
    cpu_done = 1'b0;
    cmp("sim_commit_busy", busy, 0);
    cmp("sim_commit_tick", frame_tick, 0);
    step(1);
    cmp("sim_tick", frame_tick, 1);
    cmp("sim_busy", busy, 1);
    cmp("sim_fc", frame_count, STATS ? 1 : 0);
    cmp("sim_missed", missed_count, 0);
    cmp("sim_x", disp_ball_x, 7);
    cpu_done = 1'b1; step(1); cpu_done = 1'b0; step(2);

    // done ignored while idle; held-high screenEnd fires once
    do_reset();
    screenEnd = 1'b0; cpu_done = 1'b1; step(1); cpu_done = 1'b0; step(2);
    cmp("idle_done_busy", busy, 0);
    cmp("idle_done_fc", frame_count, 0);
    t0 = ticks;
    screenEnd = 1'b1; step(100);
    cmp("held_ticks", ticks - t0, 1);
    cmp("held_busy", busy, 1);

    // reset mid-frame
    reset = 1'b1; step(1);
    reset = 1'b0; screenEnd = 1'b0;
    cmp("rstmid_tick", frame_tick, 0);
    cmp("rstmid_busy", busy, 0);
    cmp("rstmid_x", disp_ball_x, 320);
    cmp("rstmid_missed", missed_count, 0);
    step(1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) screenEnd = ~screenEnd;
      cpu_done   = ($urandom_range(0, 5) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      cpu_ball_x = rand_coord();
      cpu_ball_y = rand_coord();
      step(1);
    end
    reset = 1'b0; cpu_done = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
